// File: rtl/paillier_pkg.sv
// Shared sizing and read-FSM state encoding for the ciphertext transmit path.
// Blocks are REGISTER_SIZE bits and are sent to the UART one byte at a time.
package paillier_pkg;
  localparam int REGISTER_SIZE   = 32;
  localparam int NUM_BLOCKS      = 128;
  localparam int BYTES_PER_BLOCK = REGISTER_SIZE / 8;
  localparam int IDX_W           = $clog2(NUM_BLOCKS);
  localparam int BYTE_IDX_W      = (BYTES_PER_BLOCK > 1) ? $clog2(BYTES_PER_BLOCK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    HOLD = 2'd3
  } rd_state_e;
endpackage

// File: rtl/ciphertext_tx_buffer_if.sv
// Block-stream input and UART byte output of the ciphertext transmit buffer.
// Master is the environment (encryptor + UART); slave is the buffer.
interface ciphertext_tx_buffer_if;
  import paillier_pkg::*;

  logic                     valid_in;
  logic [REGISTER_SIZE-1:0] block_in;
  logic                     tx_ready_in;
  logic [7:0]               byte_out;
  logic                     byte_valid_out;
  logic                     frame_done_out;
  logic                     overflow_out;
  logic                     busy_out;

  modport master (
    output valid_in, block_in, tx_ready_in,
    input  byte_out, byte_valid_out, frame_done_out, overflow_out, busy_out
  );

  modport slave (
    input  valid_in, block_in, tx_ready_in,
    output byte_out, byte_valid_out, frame_done_out, overflow_out, busy_out
  );
endinterface

// File: rtl/dual_bank_bram.sv
// Simple dual-port RAM holding both ping-pong banks; address is {bank, idx}.
// Read data is registered, so it appears one cycle after rd_en.
module dual_bank_bram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk_in,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [2**ADDR_W];

  // Write port
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port
  always_ff @(posedge clk_in) begin
    if (rd_en) begin
      rd_data <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/ciphertext_tx_buffer.sv
// Ping-pong capture of streamed ciphertext blocks and LSB-first byte serialisation
// to the UART; one bank drains while the other fills.
module ciphertext_tx_buffer
  import paillier_pkg::*;
(
  input  logic                   clk_in,
  input  logic                   rst_in,
  ciphertext_tx_buffer_if.slave  bus
);

  localparam int                    ADDR_W    = IDX_W + 1;
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_BLOCKS - 1);
  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(BYTES_PER_BLOCK - 1);

  logic [IDX_W-1:0]         wr_idx_r;
  logic                     wr_bank_r;
  logic [1:0]               full_r;
  logic [1:0]               full_nxt_s;
  logic [1:0]               set_full_s;
  logic [1:0]               clr_full_s;
  logic                     overflow_r;
  logic                     wr_accept_s;
  logic                     wr_last_s;

  rd_state_e                state_r;
  rd_state_e                state_nxt_s;
  logic                     rd_bank_r;
  logic                     rd_bank_nxt_s;
  logic [IDX_W-1:0]         rd_idx_r;
  logic [IDX_W-1:0]         rd_idx_nxt_s;
  logic [BYTE_IDX_W-1:0]    byte_idx_r;
  logic [BYTE_IDX_W-1:0]    byte_idx_nxt_s;
  logic [REGISTER_SIZE-1:0] sr_r;
  logic [REGISTER_SIZE-1:0] sr_nxt_s;
  logic [REGISTER_SIZE-1:0] rd_data_s;
  logic                     rd_en_s;
  logic                     last_byte_s;
  logic                     last_block_s;

  logic [7:0]               byte_r;
  logic [7:0]               byte_nxt_s;
  logic                     byte_valid_r;
  logic                     byte_valid_nxt_s;
  logic                     frame_done_r;
  logic                     frame_done_nxt_s;
  logic                     busy_r;

  dual_bank_bram #(.DATA_W(REGISTER_SIZE), .ADDR_W(ADDR_W)) u_bram (
    .clk_in  (clk_in),
    .wr_en   (wr_accept_s),
    .wr_addr ({wr_bank_r, wr_idx_r}),
    .wr_data (bus.block_in),
    .rd_en   (rd_en_s),
    .rd_addr ({rd_bank_r, rd_idx_nxt_s}),
    .rd_data (rd_data_s)
  );

  // Write-side acceptance and combined full-flag update; a set and a clear never hit one bank
  always_comb begin
    wr_accept_s = bus.valid_in && !full_r[wr_bank_r];
    wr_last_s   = wr_accept_s && (wr_idx_r == LAST_IDX);
    set_full_s  = 2'b00;
    if (wr_last_s) begin
      set_full_s[wr_bank_r] = 1'b1;
    end else begin
      set_full_s = 2'b00;
    end
    full_nxt_s = (full_r & ~clr_full_s) | set_full_s;
  end

  // Write counters, bank flags and sticky overflow
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_idx_r   <= {IDX_W{1'b0}};
      wr_bank_r  <= 1'b0;
      full_r     <= 2'b00;
      overflow_r <= 1'b0;
    end else begin
      if (wr_accept_s) begin
        wr_idx_r  <= wr_last_s ? {IDX_W{1'b0}} : wr_idx_r + 1'b1;
        wr_bank_r <= wr_bank_r ^ wr_last_s;
      end
      if (bus.valid_in && full_r[wr_bank_r]) begin
        overflow_r <= 1'b1;
      end
      full_r <= full_nxt_s;
    end
  end

  assign last_byte_s  = (byte_idx_r == LAST_BYTE);
  assign last_block_s = (rd_idx_r == LAST_IDX);

  // Read FSM next-state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = full_r[rd_bank_r] ? LOAD : IDLE;
      LOAD:    state_nxt_s = SEND;
      SEND:    state_nxt_s = bus.tx_ready_in ? HOLD : SEND;
      HOLD: begin
        if (!last_byte_s) begin
          state_nxt_s = SEND;
        end else if (!last_block_s) begin
          state_nxt_s = LOAD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Read FSM outputs: BRAM reads, shifter, byte pulses and bank release
  always_comb begin
    rd_en_s          = 1'b0;
    rd_idx_nxt_s     = rd_idx_r;
    byte_idx_nxt_s   = byte_idx_r;
    sr_nxt_s         = sr_r;
    byte_nxt_s       = byte_r;
    byte_valid_nxt_s = 1'b0;
    frame_done_nxt_s = 1'b0;
    clr_full_s       = 2'b00;
    rd_bank_nxt_s    = rd_bank_r;
    case (state_r)
      IDLE: begin
        if (full_r[rd_bank_r]) begin
          rd_en_s      = 1'b1;
          rd_idx_nxt_s = {IDX_W{1'b0}};
        end else begin
          rd_en_s      = 1'b0;
        end
      end
      LOAD: begin
        sr_nxt_s       = rd_data_s;
        byte_idx_nxt_s = {BYTE_IDX_W{1'b0}};
      end
      SEND: begin
        if (bus.tx_ready_in) begin
          byte_nxt_s       = sr_r[7:0];
          byte_valid_nxt_s = 1'b1;
          sr_nxt_s         = {8'h00, sr_r[REGISTER_SIZE-1:8]};
          frame_done_nxt_s = last_byte_s && last_block_s;
        end else begin
          byte_valid_nxt_s = 1'b0;
        end
      end
      HOLD: begin
        if (!last_byte_s) begin
          byte_idx_nxt_s = byte_idx_r + 1'b1;
        end else if (!last_block_s) begin
          rd_en_s      = 1'b1;
          rd_idx_nxt_s = rd_idx_r + 1'b1;
        end else begin
          clr_full_s[rd_bank_r] = 1'b1;
          rd_bank_nxt_s         = ~rd_bank_r;
        end
      end
      default: begin
        rd_en_s = 1'b0;
      end
    endcase
  end

  // Read FSM state and datapath registers, including the registered outputs
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r      <= IDLE;
      rd_bank_r    <= 1'b0;
      rd_idx_r     <= {IDX_W{1'b0}};
      byte_idx_r   <= {BYTE_IDX_W{1'b0}};
      sr_r         <= {REGISTER_SIZE{1'b0}};
      byte_r       <= 8'h00;
      byte_valid_r <= 1'b0;
      frame_done_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      rd_bank_r    <= rd_bank_nxt_s;
      rd_idx_r     <= rd_idx_nxt_s;
      byte_idx_r   <= byte_idx_nxt_s;
      sr_r         <= sr_nxt_s;
      byte_r       <= byte_nxt_s;
      byte_valid_r <= byte_valid_nxt_s;
      frame_done_r <= frame_done_nxt_s;
      busy_r       <= (|full_nxt_s) || (state_nxt_s != IDLE);
    end
  end

  assign bus.byte_out       = byte_r;
  assign bus.byte_valid_out = byte_valid_r;
  assign bus.frame_done_out = frame_done_r;
  assign bus.overflow_out   = overflow_r;
  assign bus.busy_out       = busy_r;

endmodule

// File: tb/tb_ciphertext_tx_buffer.sv
// Directed bench for ciphertext_tx_buffer: single frame, throttled UART,
// ping-pong, overflow, mid-frame reset and idle gaps between blocks.
module tb_ciphertext_tx_buffer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ciphertext_tx_buffer_if bus ();

  ciphertext_tx_buffer dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  logic [31:0] blk_q[$];
  int          gap_q[$];
  logic [7:0]  exp_q[$];
  int          exp_done_q[$];
  logic [7:0]  got_q[$];
  int          done_q[$];

  int   n_checks   = 0;
  int   n_fail     = 0;
  int   bad_ready  = 0;
  int   bad_space  = 0;
  int   stray_done = 0;
  logic prev_v     = 1'b0;
  logic mon_rdy    = 1'b0;

  // Output monitor: samples tx_ready at the edge, DUT outputs 1 time unit later
  always @(posedge clk) begin
    mon_rdy = bus.tx_ready_in;
    #1;
    if (bus.byte_valid_out === 1'b1) begin
      got_q.push_back(bus.byte_out);
      if (mon_rdy !== 1'b1) bad_ready++;
      if (prev_v) bad_space++;
      if (bus.frame_done_out === 1'b1) done_q.push_back(got_q.size() - 1);
    end else if (bus.frame_done_out === 1'b1) begin
      stray_done++;
    end
    prev_v = (bus.byte_valid_out === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] got_at(input int i);
    logic [7:0] unknown_byte;
    unknown_byte = 8'hxx;
    return (i < got_q.size()) ? got_q[i] : unknown_byte;
  endfunction

  task automatic push_frame(input logic [31:0] base, input logic [31:0] step, input int first,
                            input int n, input int max_gap, input bit expect_out);
    logic [31:0] b;
    for (int i = first; i < first + n; i++) begin
      b = base + step * 32'(i);
      blk_q.push_back(b);
      gap_q.push_back((max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
      if (expect_out) begin
        for (int k = 0; k < 4; k++) exp_q.push_back(8'(b >> (8 * k)));
        if (i == 127) exp_done_q.push_back(exp_q.size() - 1);
      end
    end
  endtask

  // mode 0: tx_ready low, 1: high, 2: 1 cycle high / 20 low
  task automatic run(input int target, input int mode, input int budget);
    int cyc;
    cyc = 0;
    while (cyc < budget && (blk_q.size() != 0 || got_q.size() < target)) begin
      @(negedge clk);
      case (mode)
        0:       bus.tx_ready_in = 1'b0;
        1:       bus.tx_ready_in = 1'b1;
        default: bus.tx_ready_in = ((cyc % 21) == 0);
      endcase
      if (blk_q.size() != 0 && gap_q[0] == 0) begin
        bus.valid_in = 1'b1;
        bus.block_in = blk_q.pop_front();
        void'(gap_q.pop_front());
      end else begin
        bus.valid_in = 1'b0;
        if (gap_q.size() != 0) gap_q[0] = gap_q[0] - 1;
      end
      cyc++;
    end
    @(negedge clk);
    bus.valid_in = 1'b0;
    check("run_timeout", 32'(cyc < budget), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.valid_in    = 1'b0;
      bus.tx_ready_in = 1'b1;
    end
  endtask

  task automatic clear_scoreboard();
    blk_q.delete(); gap_q.delete(); exp_q.delete(); exp_done_q.delete();
    got_q.delete(); done_q.delete();
    bad_ready = 0; bad_space = 0; stray_done = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus.valid_in = 1'b0; bus.tx_ready_in = 1'b0; bus.block_in = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    clear_scoreboard();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_byte_out"},   32'(bus.byte_out),       32'd0);
    check({tag, "_byte_valid"}, 32'(bus.byte_valid_out), 32'd0);
    check({tag, "_frame_done"}, 32'(bus.frame_done_out), 32'd0);
    check({tag, "_overflow"},   32'(bus.overflow_out),   32'd0);
    check({tag, "_busy"},       32'(bus.busy_out),       32'd0);
  endtask

  task automatic finish_scenario(input string tag, input logic exp_ovf);
    int m;
    idle(60);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, "_done_count"}, 32'(done_q.size()), 32'(exp_done_q.size()));
    for (int i = 0; i < done_q.size() && i < exp_done_q.size(); i++)
      check($sformatf("%s_done%0d", tag, i), 32'(done_q[i]), 32'(exp_done_q[i]));
    check({tag, "_pulse_wo_ready"}, 32'(bad_ready), 32'd0);
    check({tag, "_back_to_back"},   32'(bad_space), 32'd0);
    check({tag, "_stray_done"},     32'(stray_done), 32'd0);
    check({tag, "_busy_end"},       32'(bus.busy_out), 32'd0);
    check({tag, "_overflow"},       32'(bus.overflow_out), 32'(exp_ovf));
  endtask

  initial begin
    bus.valid_in = 1'b0; bus.tx_ready_in = 1'b0; bus.block_in = 32'h0;

    // Reset state
    do_reset();
    check_outputs_zero("reset");

    // Single frame, UART always ready
    push_frame(32'h0000_00A5, 32'h0000_0100, 0, 128, 0, 1'b1);
    run(512, 1, 4000);
    check("single_b0", 32'(got_at(0)), 32'hA5);
    check("single_b1", 32'(got_at(1)), 32'h00);
    check("single_b2", 32'(got_at(2)), 32'h00);
    check("single_b3", 32'(got_at(3)), 32'h00);
    check("single_b4", 32'(got_at(4)), 32'hA5);
    check("single_b5", 32'(got_at(5)), 32'h01);
    check("single_b509", 32'(got_at(509)), 32'h7F);
    finish_scenario("single", 1'b0);

    // UART throttled: 1 cycle ready, 20 not ready
    do_reset();
    push_frame(32'h0000_00A5, 32'h0000_0100, 0, 128, 0, 1'b1);
    run(512, 2, 20000);
    finish_scenario("throttle", 1'b0);

    // Ping-pong: second frame streams in while the first drains
    do_reset();
    push_frame(32'h0000_00A5, 32'h0000_0100, 0, 128, 0, 1'b1);
    push_frame(32'hDEAD_BEEF, 32'h0000_0000, 0, 128, 0, 1'b1);
    run(1024, 1, 6000);
    check("pingpong_b512",  32'(got_at(512)),  32'hEF);
    check("pingpong_b513",  32'(got_at(513)),  32'hBE);
    check("pingpong_b514",  32'(got_at(514)),  32'hAD);
    check("pingpong_b1023", 32'(got_at(1023)), 32'hDE);
    finish_scenario("pingpong", 1'b0);

    // Overflow: three frames with the UART blocked
    do_reset();
    push_frame(32'h0000_00A5, 32'h0000_0100, 0, 128, 0, 1'b1);
    push_frame(32'hDEAD_BEEF, 32'h0000_0000, 0, 128, 0, 1'b1);
    run(0, 0, 400);
    check("ovf_before_f3", 32'(bus.overflow_out), 32'd0);
    check("ovf_busy_full", 32'(bus.busy_out), 32'd1);
    push_frame(32'h1111_1111, 32'h0000_0001, 0, 1, 0, 1'b0);
    run(0, 0, 10);
    check("ovf_first_f3_block", 32'(bus.overflow_out), 32'd1);
    push_frame(32'h1111_1111, 32'h0000_0001, 1, 127, 0, 1'b0);
    run(0, 0, 200);
    check("ovf_no_bytes_blocked", 32'(got_q.size()), 32'd0);
    run(1024, 1, 6000);
    finish_scenario("overflow", 1'b1);

    // Reset one cycle after byte 100, then a fresh frame
    do_reset();
    push_frame(32'h0000_00A5, 32'h0000_0100, 0, 128, 0, 1'b1);
    run(101, 1, 2000);
    check("midrst_count_at_rst", 32'(got_q.size()), 32'd101);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_outputs_zero("midrst");
    idle(200);
    check("midrst_no_more_bytes", 32'(got_q.size()), 32'd101);
    check("midrst_busy", 32'(bus.busy_out), 32'd0);
    check("midrst_b100", 32'(got_at(100)), 32'(exp_q[100]));
    clear_scoreboard();
    push_frame(32'h0000_00A5, 32'h0000_0100, 0, 128, 0, 1'b1);
    run(512, 1, 4000);
    check("midrst_fresh_b0", 32'(got_at(0)), 32'hA5);
    finish_scenario("midrst_fresh", 1'b0);

    // Random idle gaps of 0-5 cycles between blocks
    do_reset();
    push_frame(32'h0000_00A5, 32'h0000_0100, 0, 128, 5, 1'b1);
    run(512, 1, 5000);
    finish_scenario("gaps", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
